// File: rtl/wb_serial_in_if.sv
// rtl/wb_serial_in_if.sv - Wishbone slave bus bundle for the serial input port
interface wb_serial_in_if #(
  parameter int WIDTH   = 8,
  parameter int ENABLES = WIDTH / 8
);
  logic               wb_cyc_i;
  logic               wb_stb_i;
  logic               wb_we_i;
  logic               wb_ack_o;
  logic [ENABLES-1:0] wb_sel_i;
  logic [WIDTH-1:0]   wb_dat_i;
  logic [ENABLES-1:0] wb_sel_o;
  logic [WIDTH-1:0]   wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_sel_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_sel_o, wb_dat_o
  );
endinterface

// File: rtl/wb_serial_in.sv
// rtl/wb_serial_in.sv - Wishbone read port for an external 74HC165-style shift register
module wb_serial_in #(
  parameter int HIGHZ       = 0,
  parameter int WIDTH       = 8,
  parameter int ENABLES     = WIDTH / 8,
  parameter int CLKDIV      = 2,
  parameter int LOAD_CYCLES = 1
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_serial_in_if.slave  bus,
  output logic           sr_load_n_o,
  output logic           sr_clk_o,
  input  logic           sr_dat_i
);

  localparam int DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKDIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, ACK} state_t;

  state_t             state_q, state_n;
  logic [DIV_W-1:0]   div_q, div_n;
  logic [BIT_W-1:0]   bit_q, bit_n;
  logic [LOAD_W-1:0]  load_q, load_n;
  logic               half_q, half_n;
  logic [WIDTH-1:0]   shift_q, shift_n;
  logic [WIDTH-1:0]   data_q, data_n;
  logic               ack_q, ack_n;
  logic               rd_q, rd_n;
  logic               req;
  logic               unused_inputs;

  // Byte selects and write data carry no meaning for this read-only port.
  assign unused_inputs = ^{bus.wb_sel_i, bus.wb_dat_i};

  assign req = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;

  // Next-state logic: load pulse, divided shift clock, bit sampling and ack.
  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    bit_n   = bit_q;
    load_n  = load_q;
    half_n  = half_q;
    shift_n = shift_q;
    data_n  = data_q;
    ack_n   = 1'b0;
    rd_n    = 1'b0;
    case (state_q)
      IDLE: begin
        div_n  = '0;
        bit_n  = '0;
        load_n = '0;
        half_n = 1'b0;
        if (req) begin
          if (bus.wb_we_i) ack_n = 1'b1;
          else             state_n = LOAD;
        end
      end
      LOAD: begin
        if (load_q == LOAD_LAST) state_n = SHIFT;
        else                     load_n  = load_q + 1'b1;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_n = '0;
          if (!half_q) begin
            // End of the low phase: the register output is stable, take the bit.
            shift_n = {shift_q[WIDTH-2:0], sr_dat_i};
            half_n  = 1'b1;
          end else begin
            half_n = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_n = ACK;
              data_n  = shift_q;
              ack_n   = bus.wb_cyc_i & bus.wb_stb_i;
              rd_n    = bus.wb_cyc_i & bus.wb_stb_i;
            end else begin
              bit_n = bit_q + 1'b1;
            end
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; sr_* are registered so the external pins never glitch.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      load_q      <= '0;
      half_q      <= 1'b0;
      shift_q     <= '0;
      data_q      <= '0;
      ack_q       <= 1'b0;
      rd_q        <= 1'b0;
      sr_load_n_o <= 1'b1;
      sr_clk_o    <= 1'b0;
    end else begin
      state_q     <= state_n;
      div_q       <= div_n;
      bit_q       <= bit_n;
      load_q      <= load_n;
      half_q      <= half_n;
      shift_q     <= shift_n;
      data_q      <= data_n;
      ack_q       <= ack_n;
      rd_q        <= rd_n;
      sr_load_n_o <= (state_n != LOAD);
      sr_clk_o    <= (state_n == SHIFT) && half_n;
    end
  end

  assign bus.wb_ack_o = ack_q;

  generate
    if (HIGHZ != 0) begin : g_tristate
      assign bus.wb_dat_o = rd_q ? data_q : {WIDTH{1'bz}};
      assign bus.wb_sel_o = rd_q ? {ENABLES{1'b1}} : {ENABLES{1'bz}};
    end else begin : g_driven
      assign bus.wb_dat_o = data_q;
      assign bus.wb_sel_o = rd_q ? {ENABLES{1'b1}} : {ENABLES{1'b0}};
    end
  endgenerate

endmodule

// File: tb/tb_wb_serial_in.sv
// tb/tb_wb_serial_in.sv - scoreboard bench for wb_serial_in
module tb_wb_serial_in;

  typedef struct {
    bit          rd;
    logic [7:0]  dat;
    int unsigned at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cnt = 0;
  int n_chk = 0;
  int n_fail = 0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  bit   prev1 = 1'b0;
  bit   prev2 = 1'b0;

  logic load1, sclk1, sdat1;
  logic load2, sclk2, sdat2;
  logic [7:0] model1 = 8'h00, sreg1 = 8'h00;
  logic [7:0] model2 = 8'h00, sreg2 = 8'h00;
  logic pclk1 = 1'b0, pclk2 = 1'b0;

  wb_serial_in_if #(.WIDTH(8)) bus1();
  wb_serial_in_if #(.WIDTH(8)) bus2();

  wb_serial_in #(.HIGHZ(0), .WIDTH(8), .CLKDIV(2), .LOAD_CYCLES(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus1),
    .sr_load_n_o(load1), .sr_clk_o(sclk1), .sr_dat_i(sdat1)
  );

  wb_serial_in #(.HIGHZ(1), .WIDTH(8), .CLKDIV(1), .LOAD_CYCLES(1)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus2),
    .sr_load_n_o(load2), .sr_clk_o(sclk2), .sr_dat_i(sdat2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  // 74HC165 models: parallel load while load_n low, shift on sr_clk rising edge.
  always @(posedge clk) begin
    pclk1 <= sclk1;
    if (!load1) sreg1 <= model1;
    else if (sclk1 && !pclk1) sreg1 <= {sreg1[6:0], 1'b0};
    pclk2 <= sclk2;
    if (!load2) sreg2 <= model2;
    else if (sclk2 && !pclk2) sreg2 <= {sreg2[6:0], 1'b0};
  end
  assign sdat1 = sreg1[7];
  assign sdat2 = sreg2[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every ack pops one expectation and is checked against it.
  always @(negedge clk) begin
    if (bus1.wb_ack_o) begin
      chk("ack1_gap", {31'd0, prev1}, 32'd0);
      if (q1.size() == 0) begin
        chk("ack1_unexpected", cnt, 32'hFFFF_FFFF);
      end else begin
        e1 = q1.pop_front();
        chk("ack1_cycle", cnt, e1.at);
        if (e1.rd) begin
          chk("rd1_dat", {24'd0, bus1.wb_dat_o}, {24'd0, e1.dat});
          chk("rd1_sel", {31'd0, bus1.wb_sel_o}, 32'd1);
        end
      end
    end
    if (bus2.wb_ack_o) begin
      chk("ack2_gap", {31'd0, prev2}, 32'd0);
      if (q2.size() == 0) begin
        chk("ack2_unexpected", cnt, 32'hFFFF_FFFF);
      end else begin
        e2 = q2.pop_front();
        chk("ack2_cycle", cnt, e2.at);
        chk("rd2_dat", {24'd0, bus2.wb_dat_o}, {24'd0, e2.dat});
        chk("rd2_sel", {31'd0, bus2.wb_sel_o}, 32'd1);
      end
    end
    prev1 = bus1.wb_ack_o;
    prev2 = bus2.wb_ack_o;
  end

  task automatic push1(input bit rd, input logic [7:0] d, input int unsigned at);
    exp_t e;
    e.rd = rd; e.dat = d; e.at = at;
    q1.push_back(e);
  endtask

  task automatic start1(input bit we);
    bus1.wb_cyc_i = 1'b1;
    bus1.wb_stb_i = 1'b1;
    bus1.wb_we_i  = we;
    bus1.wb_dat_i = 8'h3C;
  endtask

  task automatic stop1();
    bus1.wb_cyc_i = 1'b0;
    bus1.wb_stb_i = 1'b0;
    bus1.wb_we_i  = 1'b0;
  endtask

  // Waits for an ack on dut1, counting load-low cycles, clock rises and high cycles.
  task automatic wait_ack1(output int ll, output int rises, output int highs);
    bit got;
    logic ps;
    got = 1'b0; ll = 0; rises = 0; highs = 0; ps = sclk1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (!load1) ll++;
      if (sclk1) highs++;
      if (sclk1 && !ps) rises++;
      ps = sclk1;
      if (bus1.wb_ack_o) got = 1'b1;
    end
    if (!got) chk("ack1_timeout", 32'd0, 32'd1);
  endtask

  function automatic bit released2();
    return (bus2.wb_dat_o === 8'bzzzz_zzzz) || (bus2.wb_dat_o === 8'h00);
  endfunction

  initial begin
    int ll, rises, highs;
    exp_t e;
    bit got;
    bus1.wb_cyc_i = 0; bus1.wb_stb_i = 0; bus1.wb_we_i = 0;
    bus1.wb_sel_i = 1'b1; bus1.wb_dat_i = 8'h00;
    bus2.wb_cyc_i = 0; bus2.wb_stb_i = 0; bus2.wb_we_i = 0;
    bus2.wb_sel_i = 1'b1; bus2.wb_dat_i = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, bus1.wb_ack_o}, 32'd0);
    chk("rst_load_n", {31'd0, load1}, 32'd1);
    chk("rst_sr_clk", {31'd0, sclk1}, 32'd0);
    chk("rst_dat", {24'd0, bus1.wb_dat_o}, 32'd0);
    chk("rst_sel", {31'd0, bus1.wb_sel_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Read 8'hA5 with waveform shape counts
    model1 = 8'hA5;
    push1(1'b1, 8'hA5, cnt + 1 + 33);
    start1(1'b0);
    wait_ack1(ll, rises, highs);
    stop1();
    chk("a5_load_cycles", ll, 32'd1);
    chk("a5_clk_pulses", rises, 32'd8);
    chk("a5_clk_high", highs, 32'd16);
    repeat (2) @(negedge clk);

    // Write 8'h3C: immediate ack, serial pins idle
    push1(1'b0, 8'h00, cnt + 1);
    start1(1'b1);
    wait_ack1(ll, rises, highs);
    stop1();
    chk("wr_load_idle", ll, 32'd0);
    chk("wr_clk_idle", rises, 32'd0);
    repeat (2) @(negedge clk);

    model1 = 8'h5A;
    push1(1'b1, 8'h5A, cnt + 1 + 33);
    start1(1'b0);
    wait_ack1(ll, rises, highs);
    stop1();
    repeat (2) @(negedge clk);

    // Back-to-back reads with strobe held, model FF then 00
    model1 = 8'hFF;
    push1(1'b1, 8'hFF, cnt + 1 + 33);
    start1(1'b0);
    wait_ack1(ll, rises, highs);
    model1 = 8'h00;
    push1(1'b1, 8'h00, cnt + 35);
    wait_ack1(ll, rises, highs);
    stop1();
    repeat (2) @(negedge clk);

    // Strobe dropped mid-read: no ack, data still captured
    model1 = 8'h81;
    start1(1'b0);
    repeat (10) @(negedge clk);
    stop1();
    repeat (40) @(negedge clk);
    chk("drop_dat", {24'd0, bus1.wb_dat_o}, 32'h81);
    push1(1'b0, 8'h00, cnt + 1);
    start1(1'b1);
    wait_ack1(ll, rises, highs);
    stop1();
    repeat (2) @(negedge clk);

    // Reset mid-shift aborts the read and clears captured data
    model1 = 8'h77;
    start1(1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    stop1();
    repeat (2) @(negedge clk);
    chk("mid_rst_ack", {31'd0, bus1.wb_ack_o}, 32'd0);
    chk("mid_rst_load_n", {31'd0, load1}, 32'd1);
    chk("mid_rst_sr_clk", {31'd0, sclk1}, 32'd0);
    chk("mid_rst_dat", {24'd0, bus1.wb_dat_o}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    model1 = 8'h96;
    push1(1'b1, 8'h96, cnt + 1 + 33);
    start1(1'b0);
    wait_ack1(ll, rises, highs);
    stop1();
    repeat (2) @(negedge clk);

    // Tri-state instance, CLKDIV=1: bus released except in the read ack cycle
    chk("hz_idle_released", {31'd0, released2()}, 32'd1);
    model2 = 8'hC3;
    e.rd = 1'b1; e.dat = 8'hC3; e.at = cnt + 1 + 17;
    q2.push_back(e);
    bus2.wb_cyc_i = 1'b1; bus2.wb_stb_i = 1'b1; bus2.wb_we_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus2.wb_ack_o) got = 1'b1;
      else chk("hz_released", {31'd0, released2()}, 32'd1);
    end
    if (!got) chk("ack2_timeout", 32'd0, 32'd1);
    bus2.wb_cyc_i = 1'b0; bus2.wb_stb_i = 1'b0;
    @(negedge clk);
    chk("hz_after_released", {31'd0, released2()}, 32'd1);

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
